// File: rtl/bias_add_15_if.sv
// rtl/bias_add_15_if.sv - bias/accumulator/output stream bundle for bias_add_15
interface bias_add_15_if #(
    parameter int ACC_W   = 32,
    parameter int COEFF_W = 16,
    parameter int OUT_W   = 16
);
    logic [COEFF_W-1:0] bias_V_dout;
    logic               bias_V_empty_n;
    logic               bias_V_read;
    logic [ACC_W-1:0]   acc_V_dout;
    logic               acc_V_empty_n;
    logic               acc_V_read;
    logic [OUT_W-1:0]   output_V_din;
    logic               output_V_full_n;
    logic               output_V_write;
    logic               frame_done;

    modport master (
        output bias_V_dout, bias_V_empty_n,
        output acc_V_dout, acc_V_empty_n,
        output output_V_full_n,
        input  bias_V_read, acc_V_read,
        input  output_V_din, output_V_write, frame_done
    );

    modport slave (
        input  bias_V_dout, bias_V_empty_n,
        input  acc_V_dout, acc_V_empty_n,
        input  output_V_full_n,
        output bias_V_read, acc_V_read,
        output output_V_din, output_V_write, frame_done
    );
endinterface

// File: rtl/bias_add_15.sv
// rtl/bias_add_15.sv - per-channel bias add, arithmetic shift and saturation stage
// Optional feature: define BIAS_ADD_RELU_EN to clamp negative results to zero.
module bias_add_15 #(
    parameter int ACC_W      = 32,
    parameter int COEFF_W    = 16,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 8,
    parameter int N_CH       = 16,
    parameter int N_PIX      = 64
) (
    input logic         ap_clk,
    input logic         ap_rst,
    bias_add_15_if.slave bus
);
    localparam int PIX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    typedef enum logic [0:0] {
        LOAD_BIAS = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [COEFF_W-1:0] bias_q, bias_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               last_q, last_d;

    logic               bias_rd;
    logic               acc_rd;
    logic               wr_accept;

    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shifted;
    logic [OUT_W-1:0]      result;

    // Both operands are widened by one bit so the add itself can never overflow.
    always_comb begin
        sum     = $signed({bus.acc_V_dout[ACC_W-1], bus.acc_V_dout})
                + $signed({{(ACC_W + 1 - COEFF_W){bias_q[COEFF_W-1]}}, bias_q});
        shifted = sum >>> FRAC_SHIFT;
        if (shifted > SAT_MAX) begin
            result = OUT_MAX;
        end else if (shifted < SAT_MIN) begin
            result = OUT_MIN;
        end else begin
            result = shifted[OUT_W-1:0];
        end
`ifdef BIAS_ADD_RELU_EN
        if (result[OUT_W-1]) begin
            result = '0;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        bias_d      = bias_q;
        pix_d       = pix_q;
        ch_d        = ch_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        bias_rd     = 1'b0;
        acc_rd      = 1'b0;
        wr_accept   = out_valid_q & bus.output_V_full_n;

        if (wr_accept) begin
            out_valid_d = 1'b0;
        end

        // Strobes are held low while reset is asserted, even though the state already reads LOAD_BIAS.
        if (!ap_rst) begin
            case (state_q)
                LOAD_BIAS: begin
                    bias_rd = bus.bias_V_empty_n;
                    if (bias_rd) begin
                        bias_d  = bus.bias_V_dout;
                        pix_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    acc_rd = bus.acc_V_empty_n & (~out_valid_q | bus.output_V_full_n);
                    if (acc_rd) begin
                        out_d       = result;
                        out_valid_d = 1'b1;
                        last_d      = (pix_q == PIX_LAST) && (ch_q == CH_LAST);
                        if (pix_q == PIX_LAST) begin
                            pix_d   = '0;
                            state_d = LOAD_BIAS;
                            ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                        end else begin
                            pix_d = pix_q + 1'b1;
                        end
                    end
                end
                default: state_d = LOAD_BIAS;
            endcase
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= LOAD_BIAS;
            bias_q      <= '0;
            pix_q       <= '0;
            ch_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bias_q      <= bias_d;
            pix_q       <= pix_d;
            ch_q        <= ch_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign bus.bias_V_read    = bias_rd;
    assign bus.acc_V_read     = acc_rd;
    assign bus.output_V_din   = out_q;
    assign bus.output_V_write = out_valid_q;
    assign bus.frame_done     = wr_accept & last_q;
endmodule

// File: doc/bias_add_15.md
BIAS_ADD_15 -- requirements
Module: bias_add_15

Interface
REQ-001 Parameter ACC_W, 32, signed accumulator input width.
REQ-002 Parameter COEFF_W, 16, signed bias width (equals coeff_width).
REQ-003 Parameter OUT_W, 16, signed output width.
REQ-004 Parameter FRAC_SHIFT, 8, arithmetic right shift applied after bias add.
REQ-005 Parameter N_CH, 16, output channels per frame (equals kern_s_k_15).
REQ-006 Parameter N_PIX, 64, accumulator values per channel.
REQ-007 ap_clk  in  1  single clock; all logic on rising edge.
REQ-008 ap_rst  in  1  reset, asynchronous, active-high.
REQ-009 bias_V_dout  in  COEFF_W  bias word from the upstream bias stream.
REQ-010 bias_V_empty_n  in  1  bias word available.
REQ-011 bias_V_read  out  1  bias pop strobe.
REQ-012 acc_V_dout  in  ACC_W  convolution accumulator word.
REQ-013 acc_V_empty_n  in  1  accumulator word available.
REQ-014 acc_V_read  out  1  accumulator pop strobe.
REQ-015 output_V_din  out  OUT_W  biased, scaled, saturated result.
REQ-016 output_V_full_n  in  1  downstream has space.
REQ-017 output_V_write  out  1  output push strobe.
REQ-018 frame_done  out  1  one-cycle pulse on the write of the last result of a frame.

Function
REQ-019 FSM states SHALL be LOAD_BIAS and RUN; LOAD_BIAS entered after reset.
REQ-020 LOAD_BIAS: bias_V_read = bias_V_empty_n; on a read, bias_V_dout latched into bias_reg, pix_cnt cleared, next state RUN.
REQ-021 RUN: acc_V_read = acc_V_empty_n AND (NOT out_valid OR output_V_full_n); bias_V_read = 0.
REQ-022 Each accumulator read SHALL compute sum = sext(acc,ACC_W+1) + sext(bias_reg,ACC_W+1), then shift sum arithmetically right by FRAC_SHIFT.
REQ-023 Shifted value SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and load output register; out_valid set; latency 1 cycle from acc read to output_V_write.
REQ-024 output_V_write = out_valid; output_V_din = output register; value and strobe held unchanged while output_V_full_n = 0.
REQ-025 out_valid clears when output_V_full_n = 1 and no new acc read in that cycle; read and write in same cycle sustains 1 result/cycle.
REQ-026 pix_cnt increments per acc read; read with pix_cnt = N_PIX-1 returns FSM to LOAD_BIAS and increments ch_cnt.
REQ-027 ch_cnt wraps from N_CH-1 to 0; output written for pixel N_PIX-1 of channel N_CH-1 SHALL assert frame_done in the same cycle as its accepted write.
REQ-028 LOAD_BIAS may overlap a pending output write; a new bias SHALL NOT alter an output already registered.
REQ-029 Empty inputs: no strobes asserted, state and counters hold indefinitely.

Reset
REQ-030 ap_rst asserted SHALL immediately force: state LOAD_BIAS, pix_cnt 0, ch_cnt 0, bias_reg 0, out_valid 0, output register 0.
REQ-031 During reset bias_V_read, acc_V_read, output_V_write, frame_done SHALL all be 0.
REQ-032 Reset mid-frame SHALL discard partial frame; first bias read after release is channel 0.

Configuration
REQ-033 Macro BIAS_ADD_RELU_EN defined: saturated value clamped to 0 when negative before loading output register.
REQ-034 Macro BIAS_ADD_RELU_EN undefined: signed saturated value output unchanged; no other behaviour differs.

Verification
REQ-035 Bias 0x0100, acc 0x00001000, FRAC_SHIFT 8 -> output 0x0011 one cycle after acc read.
REQ-036 Bias 0x7FFF, acc 0x7FFFFFFF -> output 0x7FFF (positive saturation); acc 0x80000000, bias 0x8000 -> 0x8000, or 0x0000 with BIAS_ADD_RELU_EN.
REQ-037 output_V_full_n low 5 cycles with out_valid set -> din/write held stable, acc_V_read 0, no data loss; streaming resumes 1/cycle.
REQ-038 Full frame N_CH=16, N_PIX=64, random empty_n/full_n -> 1024 outputs match model, exactly 16 bias reads, frame_done once on write 1024.
REQ-039 ap_rst pulsed at channel 3 pixel 10 -> all outputs 0 asynchronously, next frame restarts at channel 0 with fresh bias.
